bus_patcher: RTL and testbench



---
 rtl/bus_patcher_if.sv | 41 ++++
 rtl/bus_patcher.sv | 210 +++++++++++++++++++++
 tb/tb_bus_patcher.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_patcher_if.sv
// Bus, configuration and trace signals of the patch engine; slave side is the engine,
// master side is the bus model / co-simulation host.
interface bus_patcher_if #(
   parameter int NUM_CH = 4
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic            RD_n;
   logic            WR_n;
   logic [23:0]     addr;
   logic [7:0]      data_in;
   logic [7:0]      data_out;

   logic            cfg_we;
   logic [CH_W-1:0] cfg_ch;
   logic            cfg_en;
   logic [1:0]      cfg_mode;
   logic [23:0]     cfg_addr;
   logic [7:0]      cfg_data;
   logic [15:0]     hit_count;

   logic            trc_rd;
   logic            trc_valid;
   logic [32:0]     trc_data;
   logic            trc_ovf;
   logic            trc_clr;

   modport master (
      output RD_n, WR_n, addr, data_in,
      output cfg_we, cfg_ch, cfg_en, cfg_mode, cfg_addr, cfg_data,
      output trc_rd, trc_clr,
      input  data_out, hit_count, trc_valid, trc_data, trc_ovf
   );

   modport slave (
      input  RD_n, WR_n, addr, data_in,
      input  cfg_we, cfg_ch, cfg_en, cfg_mode, cfg_addr, cfg_data,
      input  trc_rd, trc_clr,
      output data_out, hit_count, trc_valid, trc_data, trc_ovf
   );
endinterface

// File: rtl/bus_patcher.sv
// SNES main-bus snoop/patch engine: data_out is combinational (0 cycles), counters and trace 1 cycle after start.
// No backpressure on the bus; trace pushes into a full FIFO are dropped and flagged in trc_ovf.

module bus_patcher_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         full,
   input  logic         rd_rdy,
   output logic         rd_vld,
   output logic [W-1:0] rd_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_wr;
   logic          do_rd;

   assign rd_vld = (cnt != '0);
   assign full   = (cnt == (AW+1)'(DEPTH));
   assign do_rd  = rd_rdy & rd_vld;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_wr  = wr_vld & (~full | do_rd);
   assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end
endmodule

module bus_patcher #(
   parameter int          NUM_CH      = 4,
   parameter int          TRACE_DEPTH = 16,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst,
   bus_patcher_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_FORCE  = 2'd1,
      MODE_FREEZE = 2'd2,
      MODE_RANDOM = 2'd3
   } mode_t;

   typedef struct packed {
      logic        wr;
      logic [23:0] addr;
      logic [7:0]  dat;
   } trc_ent_t;

   logic                    ch_en   [NUM_CH];
   mode_t                   ch_mode [NUM_CH];
   logic [23:0]             ch_addr [NUM_CH];
   logic [7:0]              ch_data [NUM_CH];
   logic [NUM_CH-1:0][15:0] ch_cnt;

   logic            active;
   logic            active_q;
   logic            is_wr;
   logic            start;
   logic            cfg_ok;
   logic            hit_vld;
   logic [CH_W-1:0] hit_idx;
   mode_t           win_mode;
   logic [7:0]      win_data;
   logic [15:0]     lfsr;
   logic [7:0]      rnd_hold;
   logic [7:0]      rnd_val;
   logic [7:0]      dout;

   trc_ent_t        push_dat;
   logic            push_vld;
   logic            trc_full;
   logic            trc_ovf_q;

   assign active = ~bus.RD_n | ~bus.WR_n;
   assign is_wr  = ~bus.WR_n;
   assign start  = active & ~active_q;
   assign cfg_ok = (int'(bus.cfg_ch) < NUM_CH);

   // Scan from the top so the lowest matching channel is the one left standing.
   always_comb begin
      hit_vld = 1'b0;
      hit_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_en[i] && (ch_mode[i] != MODE_PASS) && (bus.addr == ch_addr[i])) begin
            hit_vld = 1'b1;
            hit_idx = CH_W'(i);
         end
      end
   end

   assign win_mode = ch_mode[hit_idx];
   assign win_data = ch_data[hit_idx];
   assign rnd_val  = start ? lfsr[7:0] : rnd_hold;

   always_comb begin
      dout = bus.data_in;
      if (active && hit_vld) begin
         case (win_mode)
            MODE_FORCE:  if (!is_wr) dout = win_data;
            MODE_FREEZE: dout = win_data;
            MODE_RANDOM: dout = rnd_val & win_data;
            default:     dout = bus.data_in;
         endcase
      end
   end

   assign bus.data_out = dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ch_en[i]   <= 1'b0;
            ch_mode[i] <= MODE_PASS;
            ch_addr[i] <= '0;
            ch_data[i] <= '0;
         end
      end else if (bus.cfg_we && cfg_ok) begin
         ch_en[bus.cfg_ch]   <= bus.cfg_en;
         ch_mode[bus.cfg_ch] <= mode_t'(bus.cfg_mode);
         ch_addr[bus.cfg_ch] <= bus.cfg_addr;
         ch_data[bus.cfg_ch] <= bus.cfg_data;
      end
   end

   // A config write to a channel restarts its count even if it also hits this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cfg_we && (bus.cfg_ch == CH_W'(i))) begin
               ch_cnt[i] <= '0;
            end else if (start && hit_vld && (hit_idx == CH_W'(i)) && (ch_cnt[i] != 16'hFFFF)) begin
               ch_cnt[i] <= ch_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign bus.hit_count = cfg_ok ? ch_cnt[bus.cfg_ch] : 16'h0000;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q <= 1'b0;
         lfsr     <= LFSR_SEED;
         rnd_hold <= '0;
      end else begin
         active_q <= active;
         lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
         if (start) rnd_hold <= lfsr[7:0];
      end
   end

   assign push_vld      = start & hit_vld;
   assign push_dat.wr   = is_wr;
   assign push_dat.addr = bus.addr;
   assign push_dat.dat  = dout;

   bus_patcher_fifo #(
      .W     ($bits(trc_ent_t)),
      .DEPTH (TRACE_DEPTH)
   ) u_trc_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (push_vld),
      .wr_dat (push_dat),
      .full   (trc_full),
      .rd_rdy (bus.trc_rd),
      .rd_vld (bus.trc_valid),
      .rd_dat (bus.trc_data)
   );

   // Setting wins over clearing so an overflow in the clear cycle is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trc_ovf_q <= 1'b0;
      end else if (push_vld && trc_full && !bus.trc_rd) begin
         trc_ovf_q <= 1'b1;
      end else if (bus.trc_clr) begin
         trc_ovf_q <= 1'b0;
      end
   end

   assign bus.trc_ovf = trc_ovf_q;
endmodule

// File: tb/tb_bus_patcher.sv
// Directed bench for bus_patcher: force/freeze/random patching, priority, counters and trace FIFO.
module tb_bus_patcher;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bus_patcher_if #(.NUM_CH(4)) bif ();

   bus_patcher #(
      .NUM_CH      (4),
      .TRACE_DEPTH (16),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int          n_chk = 0;
   int          n_err = 0;
   logic [15:0] m_lfsr;
   logic [32:0] exp_q [$];
   logic [7:0]  rexp;

   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, act, exp);
      end
   endtask

   task automatic cfg_wr(input logic [1:0] ch, input logic en, input logic [1:0] mode,
                         input logic [23:0] a, input logic [7:0] d);
      @(negedge clk);
      bif.cfg_ch   = ch;
      bif.cfg_en   = en;
      bif.cfg_mode = mode;
      bif.cfg_addr = a;
      bif.cfg_data = d;
      bif.cfg_we   = 1'b1;
      @(negedge clk);
      bif.cfg_we   = 1'b0;
   endtask

   task automatic acc(input logic wr, input logic both, input logic [23:0] a, input logic [7:0] d,
                      input int n, input logic [7:0] exp, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bif.RD_n    = wr & ~both;
         bif.WR_n    = ~(wr | both);
         bif.addr    = a;
         bif.data_in = d;
         #1 check(tag, 40'(bif.data_out), 40'(exp));
      end
      @(negedge clk);
      bif.RD_n = 1'b1;
      bif.WR_n = 1'b1;
   endtask

   task automatic sel_check(input logic [1:0] ch, input logic [15:0] exp, input string tag);
      bif.cfg_ch = ch;
      #1 check(tag, 40'(bif.hit_count), 40'(exp));
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      @(negedge clk);
      #1;
      while (bif.trc_valid && guard < 40) begin
         if (exp_q.size() == 0) check({tag, "_extra"}, 40'(bif.trc_data), 40'h0);
         else                   check(tag, 40'(bif.trc_data), 40'(exp_q.pop_front()));
         bif.trc_rd = 1'b1;
         @(negedge clk);
         bif.trc_rd = 1'b0;
         #1;
         guard++;
      end
      check({tag, "_left"}, 40'(exp_q.size()), 40'd0);
      check({tag, "_vld"}, 40'(bif.trc_valid), 40'd0);
   endtask

   initial begin
      rst          = 1'b1;
      bif.RD_n     = 1'b1;
      bif.WR_n     = 1'b1;
      bif.addr     = '0;
      bif.data_in  = '0;
      bif.cfg_we   = 1'b0;
      bif.cfg_ch   = '0;
      bif.cfg_en   = 1'b0;
      bif.cfg_mode = '0;
      bif.cfg_addr = '0;
      bif.cfg_data = '0;
      bif.trc_rd   = 1'b0;
      bif.trc_clr  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      bif.data_in = 8'h55;
      #1;
      check("rst_dout", 40'(bif.data_out), 40'h55);
      check("rst_cnt", 40'(bif.hit_count), 40'h0);
      check("rst_vld", 40'(bif.trc_valid), 40'h0);
      check("rst_tdat", 40'(bif.trc_data), 40'h0);
      check("rst_ovf", 40'(bif.trc_ovf), 40'h0);

      // Unconfigured read passes through
      acc(1'b0, 1'b0, 24'h000085, 8'h3C, 1, 8'h3C, "t1_pass");
      #1;
      check("t1_cnt", 40'(bif.hit_count), 40'h0);
      check("t1_vld", 40'(bif.trc_valid), 40'h0);

      // FORCE on reads, writes pass, both strobes low is a write
      cfg_wr(2'd0, 1'b1, 2'd1, 24'h000085, 8'h01);
      acc(1'b0, 1'b0, 24'h000085, 8'hFF, 3, 8'h01, "t2_force");
      exp_q.push_back({1'b0, 24'h000085, 8'h01});
      #1;
      check("t2_cnt1", 40'(bif.hit_count), 40'h1);
      check("t2_vld", 40'(bif.trc_valid), 40'h1);
      check("t2_head", 40'(bif.trc_data), 40'({1'b0, 24'h000085, 8'h01}));
      acc(1'b1, 1'b0, 24'h000085, 8'hAA, 2, 8'hAA, "t2_wrpass");
      exp_q.push_back({1'b1, 24'h000085, 8'hAA});
      acc(1'b1, 1'b1, 24'h000085, 8'h5A, 1, 8'h5A, "t2_both");
      exp_q.push_back({1'b1, 24'h000085, 8'h5A});
      #1 check("t2_cnt3", 40'(bif.hit_count), 40'h3);
      drain("t2_trc");

      // Priority: ch1 FREEZE beats ch2 FORCE on the same address
      cfg_wr(2'd1, 1'b1, 2'd2, 24'h7E0019, 8'h02);
      cfg_wr(2'd2, 1'b1, 2'd1, 24'h7E0019, 8'h77);
      acc(1'b1, 1'b0, 24'h7E0019, 8'h05, 2, 8'h02, "t3_freeze_wr");
      exp_q.push_back({1'b1, 24'h7E0019, 8'h02});
      acc(1'b0, 1'b0, 24'h7E0019, 8'h05, 1, 8'h02, "t3_freeze_rd");
      exp_q.push_back({1'b0, 24'h7E0019, 8'h02});
      sel_check(2'd1, 16'd2, "t3_cnt_ch1");
      sel_check(2'd2, 16'd0, "t3_cnt_ch2");
      drain("t3_trc");

      // RANDOM: masked LFSR byte captured at start, held for the access
      cfg_wr(2'd0, 1'b1, 2'd3, 24'h000019, 8'h03);
      rexp = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bif.RD_n    = 1'b0;
         bif.addr    = 24'h000019;
         bif.data_in = 8'hFF;
         #1;
         if (i == 0) rexp = m_lfsr[7:0] & 8'h03;
         check("t4_rnd", 40'(bif.data_out), 40'(rexp));
      end
      @(negedge clk);
      bif.RD_n = 1'b1;
      exp_q.push_back({1'b0, 24'h000019, rexp});
      #1 check("t4_cnt", 40'(bif.hit_count), 40'h1);
      drain("t4_trc");

      // Trace overflow, pop+push at full, clear, set-beats-clear
      cfg_wr(2'd3, 1'b1, 2'd1, 24'h000200, 8'hC3);
      for (int k = 0; k < 16; k++) begin
         acc(1'b0, 1'b0, 24'h000200, 8'h00, 1, 8'hC3, "t5_fill");
         exp_q.push_back({1'b0, 24'h000200, 8'hC3});
      end
      #1 check("t5_ovf16", 40'(bif.trc_ovf), 40'h0);
      acc(1'b0, 1'b0, 24'h000200, 8'h00, 1, 8'hC3, "t5_fill17");
      #1;
      check("t5_ovf17", 40'(bif.trc_ovf), 40'h1);
      check("t5_cnt17", 40'(bif.hit_count), 40'd17);
      @(negedge clk);
      bif.trc_clr = 1'b1;
      @(negedge clk);
      bif.trc_clr = 1'b0;
      #1 check("t5_clr", 40'(bif.trc_ovf), 40'h0);
      @(negedge clk);
      check("t5_pp_head", 40'(bif.trc_data), 40'(exp_q[0]));
      bif.RD_n   = 1'b0;
      bif.addr   = 24'h000200;
      bif.trc_rd = 1'b1;
      @(negedge clk);
      bif.RD_n   = 1'b1;
      bif.trc_rd = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back({1'b0, 24'h000200, 8'hC3});
      #1;
      check("t5_pp_ovf", 40'(bif.trc_ovf), 40'h0);
      check("t5_pp_vld", 40'(bif.trc_valid), 40'h1);
      @(negedge clk);
      bif.RD_n    = 1'b0;
      bif.trc_clr = 1'b1;
      @(negedge clk);
      bif.RD_n    = 1'b1;
      bif.trc_clr = 1'b0;
      #1;
      check("t5_setwins", 40'(bif.trc_ovf), 40'h1);
      check("t5_cnt19", 40'(bif.hit_count), 40'd19);
      @(negedge clk);
      bif.trc_clr = 1'b1;
      @(negedge clk);
      bif.trc_clr = 1'b0;
      #1 check("t5_clr2", 40'(bif.trc_ovf), 40'h0);
      drain("t5_trc");

      // Counter saturation and clear on config write
      @(negedge clk);
      #1 force dut.ch_cnt = 64'h0000_0000_FFFE_0000;
      #1 release dut.ch_cnt;
      sel_check(2'd1, 16'hFFFE, "t6_preload");
      acc(1'b1, 1'b0, 24'h7E0019, 8'h11, 1, 8'h02, "t6_hit1");
      exp_q.push_back({1'b1, 24'h7E0019, 8'h02});
      #1 check("t6_sat1", 40'(bif.hit_count), 40'hFFFF);
      acc(1'b1, 1'b0, 24'h7E0019, 8'h12, 1, 8'h02, "t6_hit2");
      exp_q.push_back({1'b1, 24'h7E0019, 8'h02});
      #1 check("t6_sat2", 40'(bif.hit_count), 40'hFFFF);
      cfg_wr(2'd1, 1'b1, 2'd2, 24'h7E0019, 8'h02);
      #1 check("t6_cfgclr", 40'(bif.hit_count), 40'h0);
      drain("t6_trc");

      // Reset in the middle of an access
      @(negedge clk);
      bif.RD_n    = 1'b0;
      bif.addr    = 24'h7E0019;
      bif.data_in = 8'h99;
      #1 check("t7_pre_dout", 40'(bif.data_out), 40'h02);
      @(negedge clk);
      #1;
      check("t7_pre_cnt", 40'(bif.hit_count), 40'h1);
      check("t7_pre_vld", 40'(bif.trc_valid), 40'h1);
      rst = 1'b1;
      #1 check("t7_dout", 40'(bif.data_out), 40'h99);
      check("t7_vld", 40'(bif.trc_valid), 40'h0);
      check("t7_ovf", 40'(bif.trc_ovf), 40'h0);
      for (int c = 0; c < 4; c++) sel_check(2'(c), 16'h0, "t7_cnt");
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      #1 check("t7_post_dout", 40'(bif.data_out), 40'h99);
      bif.RD_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
